// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline sequencing controller and the control unit:
// controller states, forwarding selects and MIPS opcodes.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [5:0] R_FORMAT = 6'b000000;
    localparam logic [5:0] ADDIU    = 6'b001001;
    localparam logic [5:0] LW       = 6'b100011;
    localparam logic [5:0] SW       = 6'b101011;
    localparam logic [5:0] BEQ      = 6'b000100;
    localparam logic [5:0] J        = 6'b000010;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding comparator: selects the freshest producer of each ALU operand.
// A younger MEM-stage result always shadows an older WB-stage result.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_regwrite,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_regwrite,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b
);

    // Register 0 is hardwired to zero, so a write to it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_REG;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs);
        fwd_b = fwd_sel(ex_rt);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch/jump flushes, operand
// forwarding, data-memory handshake freeze and saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic [AW-1:0]    ex_rs,
    input  logic [AW-1:0]    ex_rt,
    input  logic [AW-1:0]    ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic [AW-1:0]    mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic [AW-1:0]    wb_rd,
    input  logic             wb_regwrite,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             stage_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    hz_state_t        state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       mem_acc;
    logic       req;
    logic       freeze;
    logic       load_use;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        r = v;
        if (en && (v != '1)) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    assign mem_acc = mem_memread | mem_memwrite;

    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    fwd_unit #(
        .AW(AW)
    ) u_fwd (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );

    // Handshake FSM: an ack always releases, even on the cycle the timeout would fire.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        req        = 1'b0;
        freeze     = 1'b0;
        unique case (state_q)
            RUN: begin
                req = mem_acc;
                if (mem_acc && !dmem_ack) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCW'(WAIT_MAX)) begin
                    req        = 1'b0;
                    mem_err_d  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // A frozen pipeline holds branch/load conditions; they are acted on after release.
    always_comb begin
        dmem_req    = req;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        stage_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a       = fwd_a_raw;
        fwd_b       = fwd_b_raw;
        if (rst) begin
            dmem_req = 1'b0;
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            stage_en = 1'b0;
            fwd_a    = FWD_REG;
            fwd_b    = FWD_REG;
        end else if (freeze) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            stage_en = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, !pc_we);
        flush_cnt_d = sat_inc(flush_cnt_q, ifid_flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of the controller.
module tb_hazard_ctrl;

    localparam int AW       = 5;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 5;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [AW-1:0]    id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             id_uses_rt, id_jump, ex_memread, ex_branch_taken;
    logic             mem_regwrite, mem_memread, mem_memwrite, wb_regwrite, dmem_ack;
    logic             dmem_req, pc_we, ifid_we, stage_en, ifid_flush, idex_bubble, mem_err;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(
        .AW(AW), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .dmem_ack(dmem_ack), .dmem_req(dmem_req), .pc_we(pc_we), .ifid_we(ifid_we),
        .stage_en(stage_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Model state: waiting flag, MEM_WAIT cycles spent without ack, error, counters.
    bit m_wait, m_err, m_timeout;
    int m_waited, m_stall, m_flush;
    bit e_req, e_pc, e_ifid, e_stage, e_flush, e_bub;
    int e_fa, e_fb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd_ref(input logic [AW-1:0] src);
        if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2;
        if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 1;
        return 0;
    endfunction

    task automatic model_comb();
        bit acc, frozen, lu;
        acc       = mem_memread || mem_memwrite;
        m_timeout = m_wait && !dmem_ack && (m_waited >= WAIT_MAX);
        e_req     = m_wait ? !m_timeout : acc;
        frozen    = m_wait ? (!dmem_ack && !m_timeout) : (acc && !dmem_ack);
        lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        {e_pc, e_ifid, e_stage, e_flush, e_bub} = 5'b11100;
        e_fa = fwd_ref(ex_rs);
        e_fb = fwd_ref(ex_rt);
        if (rst) begin
            {e_req, e_pc, e_ifid, e_stage} = 4'b0000;
            e_fa = 0;
            e_fb = 0;
        end else if (frozen) begin
            {e_pc, e_ifid, e_stage} = 3'b000;
        end else if (ex_branch_taken) begin
            {e_flush, e_bub} = 2'b11;
        end else if (id_jump) begin
            e_flush = 1'b1;
        end else if (lu) begin
            {e_pc, e_ifid, e_bub} = 3'b001;
        end
    endtask

    task automatic model_seq();
        if (rst) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc && m_stall < CMAX) m_stall++;
            if (e_flush && m_flush < CMAX) m_flush++;
            if (!m_wait) begin
                if ((mem_memread || mem_memwrite) && !dmem_ack) begin
                    m_wait = 1; m_waited = 0;
                end
            end else if (dmem_ack) begin
                m_wait = 0;
            end else if (m_timeout) begin
                m_wait = 0; m_err = 1;
            end else begin
                m_waited++;
            end
        end
    endtask

    // Evaluate the current cycle's combinational outputs just before the edge.
    task automatic settle();
        model_comb();
        @(negedge clk);
        chk("dmem_req", dmem_req, e_req);
        chk("pc_we", pc_we, e_pc);
        chk("ifid_we", ifid_we, e_ifid);
        chk("stage_en", stage_en, e_stage);
        chk("ifid_flush", ifid_flush, e_flush);
        chk("idex_bubble", idex_bubble, e_bub);
        chk("fwd_a", fwd_a, e_fa);
        chk("fwd_b", fwd_b, e_fb);
    endtask

    task automatic advance();
        @(posedge clk);
        model_seq();
        #1;
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic clear_inputs();
        rst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_memread = 0; ex_branch_taken = 0;
        mem_rd = 0; mem_regwrite = 0; mem_memread = 0; mem_memwrite = 0;
        wb_rd = 0; wb_regwrite = 0; dmem_ack = 0;
    endtask

    initial begin
        int ack_pct;
        clear_inputs();

        // Reset with every hazard source active: all controls held low.
        rst = 1; mem_memread = 1; ex_branch_taken = 1; id_jump = 1;
        mem_rd = 5; mem_regwrite = 1; ex_rs = 5; ex_rt = 5;
        settle();
        chk("rst_req", dmem_req, 0); chk("rst_pc", pc_we, 0);
        chk("rst_flush", ifid_flush, 0); chk("rst_fwd_a", fwd_a, 0);
        advance();
        tick();
        chk("rst_stall", stall_cnt, 0); chk("rst_flushcnt", flush_cnt, 0);
        chk("rst_err", mem_err, 0);

        clear_inputs();
        settle();
        chk("idle_pc", pc_we, 1); chk("idle_stage", stage_en, 1);
        advance();

        // Load-use on rs: one bubble cycle.
        ex_memread = 1; ex_rd = 8; id_rs = 8;
        settle();
        chk("lu_pc", pc_we, 0); chk("lu_ifid", ifid_we, 0);
        chk("lu_bub", idex_bubble, 1); chk("lu_stage", stage_en, 1);
        advance();
        chk("lu_stall_cnt", stall_cnt, 1);
        clear_inputs();
        settle();
        chk("lu_after_pc", pc_we, 1);
        advance();

        // Load-use on rt only counts when rt is read.
        ex_memread = 1; ex_rd = 9; id_rt = 9; id_rs = 3;
        settle(); chk("rt_unused_pc", pc_we, 1); advance();
        id_uses_rt = 1;
        settle(); chk("rt_used_pc", pc_we, 0); advance();
        clear_inputs();

        // Taken branch overrides a simultaneous load-use.
        ex_branch_taken = 1; ex_memread = 1; ex_rd = 8; id_rs = 8;
        settle();
        chk("br_flush", ifid_flush, 1); chk("br_bub", idex_bubble, 1); chk("br_pc", pc_we, 1);
        advance();
        chk("br_flush_cnt", flush_cnt, 1);
        clear_inputs();
        id_jump = 1;
        settle();
        chk("j_flush", ifid_flush, 1); chk("j_bub", idex_bubble, 0); chk("j_pc", pc_we, 1);
        advance();
        chk("j_flush_cnt", flush_cnt, 2);
        clear_inputs();

        // Forwarding priority and the zero register.
        mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1; ex_rs = 5; ex_rt = 5;
        settle(); chk("fwd_mem_a", fwd_a, 2); chk("fwd_mem_b", fwd_b, 2); advance();
        mem_regwrite = 0;
        settle(); chk("fwd_wb_a", fwd_a, 1); advance();
        wb_rd = 0; mem_rd = 0; mem_regwrite = 1; ex_rs = 0;
        settle(); chk("fwd_zero_a", fwd_a, 0); advance();
        clear_inputs();

        // Three-wait access with a branch held during the freeze.
        mem_memread = 1; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_req", dmem_req, 1); chk("mw_stage", stage_en, 0); chk("mw_flush", ifid_flush, 0);
            advance();
        end
        dmem_ack = 1;
        settle();
        chk("mw_ack_req", dmem_req, 1); chk("mw_ack_stage", stage_en, 1);
        chk("mw_ack_flush", ifid_flush, 1);
        advance();
        clear_inputs();
        settle(); chk("mw_done_req", dmem_req, 0); advance();

        // Zero-wait write.
        mem_memwrite = 1; dmem_ack = 1;
        settle(); chk("zw_req", dmem_req, 1); chk("zw_stage", stage_en, 1); advance();
        clear_inputs();

        // Timeout: entry cycle plus WAIT_MAX frozen wait cycles, then release with error.
        mem_memread = 1;
        for (int i = 0; i <= WAIT_MAX; i++) begin
            settle(); chk("to_frozen", stage_en, 0); advance();
        end
        settle();
        chk("to_req", dmem_req, 0); chk("to_stage", stage_en, 1);
        advance();
        chk("to_err", mem_err, 1);
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            settle(); chk("to_run_pc", pc_we, 1); advance();
            chk("to_err_sticky", mem_err, 1);
        end

        // Ack on the timeout cycle wins.
        rst = 1; tick(); clear_inputs();
        mem_memread = 1;
        for (int i = 0; i <= WAIT_MAX; i++) tick();
        dmem_ack = 1;
        settle(); chk("ato_req", dmem_req, 1); chk("ato_stage", stage_en, 1); advance();
        chk("ato_err", mem_err, 0);
        clear_inputs();

        // Reset during MEM_WAIT abandons the access.
        mem_memread = 1;
        tick(); tick();
        rst = 1;
        settle(); chk("rmw_req", dmem_req, 0); advance();
        clear_inputs();
        settle(); chk("rmw_pc", pc_we, 1); chk("rmw_req_after", dmem_req, 0); advance();
        chk("rmw_stall", stall_cnt, 0); chk("rmw_flushcnt", flush_cnt, 0);

        // Stall counter saturation.
        ex_memread = 1; ex_rd = 4; id_rs = 4;
        for (int i = 0; i < CMAX + 8; i++) tick();
        chk("sat_stall", stall_cnt, CMAX);
        clear_inputs();

        // Random traffic with narrow register indices to provoke matches.
        ack_pct = 40;
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) ack_pct = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(20, 80);
            rst             = ($urandom_range(0, 99) == 0);
            id_rs           = AW'($urandom_range(0, 3));
            id_rt           = AW'($urandom_range(0, 3));
            id_uses_rt      = $urandom_range(0, 1);
            id_jump         = ($urandom_range(0, 7) == 0);
            ex_rs           = AW'($urandom_range(0, 3));
            ex_rt           = AW'($urandom_range(0, 3));
            ex_rd           = AW'($urandom_range(0, 3));
            ex_memread      = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_rd          = AW'($urandom_range(0, 3));
            mem_regwrite    = $urandom_range(0, 1);
            mem_memread     = ($urandom_range(0, 3) == 0);
            mem_memwrite    = ($urandom_range(0, 5) == 0);
            wb_rd           = AW'($urandom_range(0, 3));
            wb_regwrite     = $urandom_range(0, 1);
            dmem_ack        = ($urandom_range(0, 99) < ack_pct);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS datapath driven by `control_pipelined`. It does four things:
- detects load-use hazards and inserts bubbles;
- flushes wrong-path instructions on taken branches and jumps;
- generates EX-stage forwarding selects;
- freezes the pipeline while the data memory handshake is outstanding.

It also maintains saturating stall and flush performance counters.

## Interface
- `AW`, 5: register address width.
- `WAIT_MAX`, 15: max cycles in MEM_WAIT before timeout.
- `CNT_W`, 16: performance counter width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `id_rs`, `id_rt` in AW: source registers of the instruction in ID.
- `id_uses_rt` in 1: ID instruction reads rt (R-format, SW, BEQ).
- `id_jump` in 1: J decoded in ID.
- `ex_rs`, `ex_rt` in AW: sources of the instruction in EX.
- `ex_rd` in AW: destination (post-RegDst) in EX.
- `ex_memread` in 1: EX instruction is LW.
- `ex_branch_taken` in 1: BEQ in EX resolved taken.
- `mem_rd` in AW: destination in MEM.
- `mem_regwrite` in 1: MEM instruction writes a register.
- `mem_memread`, `mem_memwrite` in 1: MEM instruction accesses data memory.
- `wb_rd` in AW: destination in WB.
- `wb_regwrite` in 1: WB instruction writes a register.
- `dmem_ack` in 1: data memory completes the access this cycle.
- `dmem_req` out 1: data memory access request.
- `pc_we`, `ifid_we` out 1: PC and IF/ID write enables.
- `stage_en` out 1: enable for ID/EX, EX/MEM, MEM/WB.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `idex_bubble` out 1: ID/EX loads all-zero control.
- `fwd_a`, `fwd_b` out 2: ALU operand select (00 regfile, 01 WB, 10 MEM).
- `mem_err` out 1: sticky, set on handshake timeout.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating counters.

## Operation
**FSM states:** RUN and MEM_WAIT.

**`mem_acc`** = `mem_memread | mem_memwrite`.

**RUN**
- `dmem_req = mem_acc`.
- If `mem_acc` and `!dmem_ack`, enter MEM_WAIT this cycle and freeze.
- An ack in the same cycle is zero-wait: no freeze.

**MEM_WAIT**
- `dmem_req = 1`; freeze.
- `wait_cnt` increments each cycle.
- On `dmem_ack`: freeze released in that cycle, `wait_cnt` cleared, next state RUN.
- If `wait_cnt` reaches WAIT_MAX with no ack: set `mem_err`, deassert `dmem_req`, release the freeze, return to RUN.

**Freeze**
- `pc_we = ifid_we = stage_en = 0`.
- `ifid_flush = idex_bubble = 0`.
- A branch or load condition stays present and is applied after release.

**Priority when not frozen:** branch > jump > load-use.
- **Taken branch:** `ifid_flush = 1`, `idex_bubble = 1`; PC loads the target (`pc_we = 1`).
- **Jump:** `ifid_flush = 1` only.
- **Load-use:** `ex_memread` and `ex_rd != 0` and (`ex_rd == id_rs` or (`id_uses_rt` and `ex_rd == id_rt`)).
  - Drives `pc_we = 0`, `ifid_we = 0`, `idex_bubble = 1`.
  - Lasts exactly one cycle, since the load has moved to MEM on the next cycle.
- **Otherwise:** all enables 1, flushes 0.

**Forwarding** (independent of freeze)
- `fwd_a = 10` if `mem_regwrite`, `mem_rd != 0` and `mem_rd == ex_rs`.
- Else `01` if `wb_regwrite`, `wb_rd != 0` and `wb_rd == ex_rs`.
- Else `00`.
- `fwd_b` is the same with `ex_rt`. MEM wins over WB.

**Counters**
- `stall_cnt` += 1 each cycle with `pc_we = 0`.
- `flush_cnt` += 1 each cycle with `ifid_flush = 1`.
- Both saturate at all-ones.

## Timing
- Stall, flush and forwarding outputs are combinational from inputs and the registered state, so they act the same cycle.
- FSM state, `wait_cnt`, `mem_err` and the counters are registered.
- **While `rst` is high:**
  - `dmem_req`, `pc_we`, `ifid_we`, `stage_en`, `ifid_flush`, `idex_bubble` = 0; `fwd_a`, `fwd_b` = 00.
  - On the edge: state RUN, `wait_cnt = 0`, `mem_err = 0`, `stall_cnt = flush_cnt = 0`.
- **Reset during MEM_WAIT** abandons the access: `dmem_req` drops in the reset cycle.
- **Ack exactly at the timeout cycle:** ack wins; `mem_err` stays 0.
- **Branch taken while load-use also matches:** the branch handles it, since the ID instruction is squashed anyway; no PC stall.
- **Counter saturation:** stays at 2^CNT_W-1.

## Structure
- **`hazard_pkg`:**
  - state enum (RUN, MEM_WAIT);
  - forwarding constants `FWD_REG=2'b00`, `FWD_WB=2'b01`, `FWD_MEM=2'b10`;
  - shared opcode constants (R_FORMAT, ADDIU, LW, SW, BEQ, J), also used by the control unit.
- **Sub-module `fwd_unit`:** purely combinational forwarding comparator, instantiated once for both operands.
- **Top:** FSM, hazard logic and counters.

## Test plan
- **Load-use:** `ex_memread=1`, `ex_rd=8`, `id_rs=8` → exactly one cycle of `pc_we=0`, `ifid_we=0`, `idex_bubble=1`; `stall_cnt=1`.
- **Taken branch and jump:**
  - `ex_branch_taken=1` → `ifid_flush=1`, `idex_bubble=1`, `pc_we=1`.
  - `id_jump=1` → `ifid_flush=1` only.
  - `flush_cnt` increments by one for each.
- **Forwarding:**
  - `mem_rd=wb_rd=5`, both regwrite, `ex_rs=5` → `fwd_a=10`.
  - `mem_regwrite=0` → `fwd_a=01`.
  - `rd=0` → `fwd_a=00`.
- **Memory wait:**
  - `mem_memread=1`, `dmem_ack` after 3 cycles → `dmem_req` high for 4 cycles; `stage_en=0` for 3 cycles, then 1 in the ack cycle.
  - Zero-wait ack → no freeze.
- **Timeout:** no ack → after WAIT_MAX=15 wait cycles `mem_err=1`, `dmem_req=0`, state RUN; `mem_err` stays set until `rst`.
- **Reset mid-wait:** assert `rst` during MEM_WAIT → `dmem_req=0` immediately; after release, all counters 0 and state RUN.
